// File: rtl/assert_ctrl_pkg.sv
// Shared types and constants for the assertion-control unit.
package assert_ctrl_pkg;

  // Control operation carried on cmd_op; unlisted encodings act as no-ops.
  typedef enum logic [3:0] {
    OpNone         = 4'd0,
    OpLock         = 4'd1,
    OpUnlock       = 4'd2,
    OpOn           = 4'd3,
    OpOff          = 4'd4,
    OpKill         = 4'd5,
    OpPassOn       = 4'd6,
    OpPassOff      = 4'd7,
    OpFailOn       = 4'd8,
    OpFailOff      = 4'd9,
    OpNonvacuousOn = 4'd10,
    OpVacuousOff   = 4'd11,
    OpVacuousOn    = 4'd12
  } op_e;

  // Assertion-type mask bits.
  localparam logic [7:0] AtypeConcurrent = 8'h01;
  localparam logic [7:0] AtypeSImmediate = 8'h02;
  localparam logic [7:0] AtypeDImmediate = 8'h0C;
  localparam logic [7:0] AtypeExpect     = 8'h10;
  localparam logic [7:0] AtypeUnique     = 8'h20;
  localparam logic [7:0] AtypeUnique0    = 8'h40;
  localparam logic [7:0] AtypePriority   = 8'h80;

  // Directive-type mask bits.
  localparam logic [2:0] DtypeAssert = 3'b001;
  localparam logic [2:0] DtypeCover  = 3'b010;
  localparam logic [2:0] DtypeAssume = 3'b100;

  // Checker event kind.
  typedef enum logic [1:0] {
    EvPass     = 2'd0,
    EvFail     = 2'd1,
    EvVacuous  = 2'd2,
    EvReserved = 2'd3
  } ev_kind_e;

  // Per-channel control state.
  typedef struct packed {
    logic locked;
    logic enabled;
    logic pass_en;
    logic fail_en;
    logic vac_en;
  } ch_state_t;

  localparam ch_state_t ChStateReset = '{
    locked:  1'b0,
    enabled: 1'b1,
    pass_en: 1'b1,
    fail_en: 1'b1,
    vac_en:  1'b1
  };

  // Next control state of a selected channel; a locked channel only honours UNLOCK.
  function automatic ch_state_t apply_op(ch_state_t s, logic [3:0] op);
    ch_state_t r;
    r = s;
    if (s.locked) begin
      if (op == OpUnlock) r.locked = 1'b0;
    end else begin
      case (op_e'(op))
        OpLock:         r.locked  = 1'b1;
        OpOn:           r.enabled = 1'b1;
        OpOff:          r.enabled = 1'b0;
        OpPassOn:       r.pass_en = 1'b1;
        OpPassOff:      r.pass_en = 1'b0;
        OpFailOn:       r.fail_en = 1'b1;
        OpFailOff:      r.fail_en = 1'b0;
        OpNonvacuousOn: r.vac_en  = 1'b1;
        OpVacuousOn:    r.vac_en  = 1'b1;
        OpVacuousOff:   r.vac_en  = 1'b0;
        default:        ;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/assert_ctrl_chan.sv
// One monitored channel: control state, command select, event gating and counters.
module assert_ctrl_chan
  import assert_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             apply_i,
  input  logic [3:0]       op_i,
  input  logic [7:0]       atype_i,
  input  logic [2:0]       dtype_i,
  input  logic             chan_hit_i,
  input  logic [7:0]       ch_atype_i,
  input  logic [2:0]       ch_dtype_i,
  input  logic             kill_i,
  input  logic             ev_valid_i,
  input  logic [1:0]       ev_kind_i,
  output logic             sel_unlocked_o,
  output logic             enabled_o,
  output logic             pass_act_o,
  output logic             fail_hit_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic [CNT_W-1:0] vac_cnt_o
);

  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0] vac_cnt_q, vac_cnt_d;
  logic             pass_act_q, pass_act_d;
  logic             sel;
  logic             count_en;
  ev_kind_e         kind;

  // Command select, state update and event gating (events see the pre-update state).
  always_comb begin
    sel            = chan_hit_i && (|(ch_atype_i & atype_i)) && (|(ch_dtype_i & dtype_i));
    sel_unlocked_o = sel && !state_q.locked;
    state_d        = state_q;
    if (apply_i && sel) state_d = apply_op(state_q, op_i);

    kind       = ev_kind_e'(ev_kind_i);
    count_en   = ev_valid_i && state_q.enabled && !kill_i;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    vac_cnt_d  = vac_cnt_q;
    if (count_en && kind == EvPass && pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + 1'b1;
    if (count_en && kind == EvFail && fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
    if (count_en && kind == EvVacuous && vac_cnt_q != '1) vac_cnt_d = vac_cnt_q + 1'b1;

    pass_act_d = count_en && ((kind == EvPass && state_q.pass_en) ||
                              (kind == EvVacuous && state_q.vac_en));
    fail_hit_o = count_en && kind == EvFail && state_q.fail_en;
  end

  // Channel state, counters and registered pass-action pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ChStateReset;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      vac_cnt_q  <= '0;
      pass_act_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      vac_cnt_q  <= vac_cnt_d;
      pass_act_q <= pass_act_d;
    end
  end

  assign enabled_o  = state_q.enabled;
  assign pass_act_o = pass_act_q;
  assign pass_cnt_o = pass_cnt_q;
  assign fail_cnt_o = fail_cnt_q;
  assign vac_cnt_o  = vac_cnt_q;

endmodule

// File: rtl/assert_ctrl_unit.sv
// Assertion-control unit: command FSM, kill window, channel array, fail encode, readout.
module assert_ctrl_unit
  import assert_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned KILL_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd_op,
  input  logic [7:0]          cmd_atype,
  input  logic [2:0]          cmd_dtype,
  input  logic [NUM_CH-1:0]   cmd_ch_mask,
  input  logic [NUM_CH*8-1:0] ch_atype,
  input  logic [NUM_CH*3-1:0] ch_dtype,
  input  logic [NUM_CH-1:0]   ev_valid,
  input  logic [NUM_CH*2-1:0] ev_kind,
  output logic [NUM_CH-1:0]   ch_enable,
  output logic [NUM_CH-1:0]   ch_kill,
  output logic [NUM_CH-1:0]   pass_act,
  output logic                fail_act,
  output logic [4:0]          fail_ch,
  output logic                fail_multi,
  input  logic [4:0]          rd_ch,
  output logic [CNT_W-1:0]    rd_pass,
  output logic [CNT_W-1:0]    rd_fail,
  output logic [CNT_W-1:0]    rd_vac
);

  localparam int unsigned KillW = $clog2(KILL_LEN + 1);

  typedef enum logic [1:0] {StIdle, StApply, StKill} st_e;

  st_e               state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [7:0]        atype_q, atype_d;
  logic [2:0]        dtype_q, dtype_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [KillW-1:0]  kill_cnt_q, kill_cnt_d;
  logic [NUM_CH-1:0] kill_mask_q, kill_mask_d;
  logic              fail_act_q, fail_act_d;
  logic [4:0]        fail_ch_q, fail_ch_d;
  logic              fail_multi_q, fail_multi_d;

  logic              apply;
  logic              all_ch;
  logic [NUM_CH-1:0] sel_unlocked;
  logic [NUM_CH-1:0] fail_hit;
  logic [CNT_W-1:0]  pass_cnt [NUM_CH];
  logic [CNT_W-1:0]  fail_cnt [NUM_CH];
  logic [CNT_W-1:0]  vac_cnt  [NUM_CH];

  assign apply     = (state_q == StApply);
  assign all_ch    = (mask_q == '0);
  assign cmd_ready = (state_q == StIdle);
  // The counter's final zero cycle is a trailing gap, so kill is held exactly KILL_LEN cycles.
  assign ch_kill   = (state_q == StKill && kill_cnt_q != '0) ? kill_mask_q : '0;

  // Command FSM next state: latch on accept, apply for one cycle, optional kill window.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    atype_d     = atype_q;
    dtype_d     = dtype_q;
    mask_d      = mask_q;
    kill_cnt_d  = kill_cnt_q;
    kill_mask_d = kill_mask_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          atype_d = cmd_atype;
          dtype_d = cmd_dtype;
          mask_d  = cmd_ch_mask;
          state_d = StApply;
        end
      end
      StApply: begin
        if (op_q == OpKill) begin
          kill_cnt_d  = KillW'(KILL_LEN);
          kill_mask_d = sel_unlocked;
          state_d     = StKill;
        end else begin
          state_d = StIdle;
        end
      end
      StKill: begin
        if (kill_cnt_q == '0) begin
          kill_mask_d = '0;
          state_d     = StIdle;
        end else begin
          kill_cnt_d = kill_cnt_q - KillW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Command FSM and latched command registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= '0;
      atype_q     <= '0;
      dtype_q     <= '0;
      mask_q      <= '0;
      kill_cnt_q  <= '0;
      kill_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      atype_q     <= atype_d;
      dtype_q     <= dtype_d;
      mask_q      <= mask_d;
      kill_cnt_q  <= kill_cnt_d;
      kill_mask_q <= kill_mask_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assert_ctrl_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk_i          (clk),
      .rst_i          (rst),
      .apply_i        (apply),
      .op_i           (op_q),
      .atype_i        (atype_q),
      .dtype_i        (dtype_q),
      .chan_hit_i     (all_ch || mask_q[i]),
      .ch_atype_i     (ch_atype[i*8 +: 8]),
      .ch_dtype_i     (ch_dtype[i*3 +: 3]),
      .kill_i         (ch_kill[i]),
      .ev_valid_i     (ev_valid[i]),
      .ev_kind_i      (ev_kind[i*2 +: 2]),
      .sel_unlocked_o (sel_unlocked[i]),
      .enabled_o      (ch_enable[i]),
      .pass_act_o     (pass_act[i]),
      .fail_hit_o     (fail_hit[i]),
      .pass_cnt_o     (pass_cnt[i]),
      .fail_cnt_o     (fail_cnt[i]),
      .vac_cnt_o      (vac_cnt[i])
    );
  end

  // Lowest failing channel and multi-fail flag.
  always_comb begin
    fail_act_d   = |fail_hit;
    fail_ch_d    = '0;
    fail_multi_d = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fail_hit[i]) fail_ch_d = 5'(i);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (fail_hit[i] && fail_ch_d != 5'(i)) fail_multi_d = 1'b1;
    end
  end

  // Registered fail report.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_act_q   <= 1'b0;
      fail_ch_q    <= '0;
      fail_multi_q <= 1'b0;
    end else begin
      fail_act_q   <= fail_act_d;
      fail_ch_q    <= fail_ch_d;
      fail_multi_q <= fail_multi_d;
    end
  end

  assign fail_act   = fail_act_q;
  assign fail_ch    = fail_ch_q;
  assign fail_multi = fail_multi_q;

  // Counter readout; out-of-range channel reads as zero.
  always_comb begin
    rd_pass = '0;
    rd_fail = '0;
    rd_vac  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == 5'(i)) begin
        rd_pass = pass_cnt[i];
        rd_fail = fail_cnt[i];
        rd_vac  = vac_cnt[i];
      end
    end
  end

endmodule

// File: tb/tb_assert_ctrl_unit.sv
// Directed bench for assert_ctrl_unit: command table plus multi-cycle corner sequences.
module tb_assert_ctrl_unit;

  localparam int NCH = 8;
  localparam int CW  = 4;
  localparam int KL  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [3:0]     cmd_op;
  logic [7:0]     cmd_atype;
  logic [2:0]     cmd_dtype;
  logic [NCH-1:0] cmd_ch_mask;
  logic [NCH*8-1:0] ch_atype;
  logic [NCH*3-1:0] ch_dtype;
  logic [NCH-1:0] ev_valid;
  logic [NCH*2-1:0] ev_kind;
  logic [NCH-1:0] ch_enable;
  logic [NCH-1:0] ch_kill;
  logic [NCH-1:0] pass_act;
  logic           fail_act;
  logic [4:0]     fail_ch;
  logic           fail_multi;
  logic [4:0]     rd_ch;
  logic [CW-1:0]  rd_pass;
  logic [CW-1:0]  rd_fail;
  logic [CW-1:0]  rd_vac;

  int total = 0;
  int bad   = 0;

  assert_ctrl_unit #(
    .NUM_CH   (NCH),
    .CNT_W    (CW),
    .KILL_LEN (KL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_atype   (cmd_atype),
    .cmd_dtype   (cmd_dtype),
    .cmd_ch_mask (cmd_ch_mask),
    .ch_atype    (ch_atype),
    .ch_dtype    (ch_dtype),
    .ev_valid    (ev_valid),
    .ev_kind     (ev_kind),
    .ch_enable   (ch_enable),
    .ch_kill     (ch_kill),
    .pass_act    (pass_act),
    .fail_act    (fail_act),
    .fail_ch     (fail_ch),
    .fail_multi  (fail_multi),
    .rd_ch       (rd_ch),
    .rd_pass     (rd_pass),
    .rd_fail     (rd_fail),
    .rd_vac      (rd_vac)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]     op;
    logic [7:0]     atype;
    logic [2:0]     dtype;
    logic [NCH-1:0] mask;
    logic [NCH-1:0] exp_en;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    if (!cmd_ready) chk({name, "_ready_timeout"}, 32'(cmd_ready), 32'd1);
  endtask

  // Present a command and return just after the accept edge (APPLY cycle).
  task automatic send_cmd(input logic [3:0] op, input logic [7:0] at, input logic [2:0] dt,
                          input logic [NCH-1:0] m);
    wait_ready("send");
    cmd_op      = op;
    cmd_atype   = at;
    cmd_dtype   = dt;
    cmd_ch_mask = m;
    cmd_valid   = 1'b1;
    step();
    cmd_valid   = 1'b0;
  endtask

  // One-cycle event strobe, all strobed channels with the same kind.
  task automatic event1(input logic [NCH-1:0] v, input logic [1:0] k);
    ev_valid = v;
    ev_kind  = {NCH{k}};
    step();
    ev_valid = '0;
  endtask

  initial begin
    int kill_hi, ready_lo, kill_bad;
    logic [NCH-1:0] prev_en;

    // ch0,1,3,5 CONCURRENT; ch2 S_IMM; ch4 EXPECT; ch6 UNIQUE; ch7 PRIORITY. ch1 COVER, ch6 ASSUME.
    ch_atype = {8'h80, 8'h20, 8'h01, 8'h10, 8'h01, 8'h02, 8'h01, 8'h01};
    ch_dtype = {3'd1, 3'd4, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd1};
    cmd_valid = 1'b0; cmd_op = '0; cmd_atype = '0; cmd_dtype = '0; cmd_ch_mask = '0;
    ev_valid = '0; ev_kind = '0; rd_ch = 5'd0;

    tbl[0] = '{4'd3,  8'hFF, 3'd7, 8'h03, 8'h03}; // ON ch0,1
    tbl[1] = '{4'd3,  8'h20, 3'd7, 8'h00, 8'h43}; // ON UNIQUE -> ch6
    tbl[2] = '{4'd4,  8'hFF, 3'd2, 8'h00, 8'h41}; // OFF COVER -> ch1
    tbl[3] = '{4'd13, 8'hFF, 3'd7, 8'h00, 8'h41}; // undefined op
    tbl[4] = '{4'd3,  8'h10, 3'd1, 8'h00, 8'h51}; // ON EXPECT/ASSERT -> ch4
    tbl[5] = '{4'd1,  8'hFF, 3'd7, 8'h04, 8'h51}; // LOCK ch2
    tbl[6] = '{4'd3,  8'hFF, 3'd7, 8'h00, 8'hFB}; // ON all, ch2 locked
    tbl[7] = '{4'd4,  8'hFF, 3'd7, 8'h04, 8'hFB}; // OFF ch2 ignored
    tbl[8] = '{4'd2,  8'hFF, 3'd7, 8'h04, 8'hFB}; // UNLOCK ch2
    tbl[9] = '{4'd3,  8'hFF, 3'd7, 8'h04, 8'hFF}; // ON ch2

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    step();

    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_enable", 32'(ch_enable), 32'hFF);
    chk("rst_kill", 32'(ch_kill), 32'h0);
    chk("rst_pass_act", 32'(pass_act), 32'h0);
    chk("rst_fail", 32'({fail_act, fail_ch, fail_multi}), 32'h0);
    chk("rst_cnt", 32'({rd_pass, rd_fail, rd_vac}), 32'h0);

    // VACUOUSOFF on CONCURRENT|EXPECT: vacuous counted but silent on ch0.
    send_cmd(4'd11, 8'h11, 3'd7, 8'h00);
    wait_ready("vacoff");
    event1(8'h01, 2'd2);
    chk("vac_pass_act", 32'(pass_act), 32'h0);
    chk("vac_cnt", 32'(rd_vac), 32'd1);
    event1(8'h05, 2'd0);
    chk("pass_act_pulse", 32'(pass_act), 32'h05);
    chk("pass_cnt", 32'(rd_pass), 32'd1);
    event1(8'h04, 2'd2);
    chk("vac_on_ch2", 32'(pass_act), 32'h04);
    step();
    chk("pass_act_single", 32'(pass_act), 32'h0);

    // OFF everything: fails neither counted nor reported.
    send_cmd(4'd4, 8'hFF, 3'd7, 8'h00);
    wait_ready("offall");
    chk("off_all", 32'(ch_enable), 32'h00);
    for (int i = 0; i < 3; i++) begin
      event1(8'h01, 2'd1);
      chk("off_fail_act", 32'(fail_act), 32'd0);
    end
    chk("off_fail_cnt", 32'(rd_fail), 32'd0);

    // Command table: enable bits unchanged during APPLY, updated after it.
    for (int i = 0; i < 10; i++) begin
      prev_en = ch_enable;
      send_cmd(tbl[i].op, tbl[i].atype, tbl[i].dtype, tbl[i].mask);
      chk($sformatf("tbl%0d_apply_en", i), 32'(ch_enable), 32'(prev_en));
      chk($sformatf("tbl%0d_apply_rdy", i), 32'(cmd_ready), 32'd0);
      step();
      chk($sformatf("tbl%0d_rdy", i), 32'(cmd_ready), 32'd1);
      chk($sformatf("tbl%0d_en", i), 32'(ch_enable), 32'(tbl[i].exp_en));
    end

    // KILL CONCURRENT/ASSERT -> ch0,3,5; pass events mid-window on ch0 (killed) and ch1 (not).
    send_cmd(4'd5, 8'h01, 3'd1, 8'h00);
    kill_hi = 0; ready_lo = 0; kill_bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (ch_kill == 8'h29) kill_hi++;
      else if (ch_kill != 8'h00) kill_bad++;
      if (!cmd_ready) ready_lo++;
      if (kill_hi == 1 && ch_kill == 8'h29) begin
        ev_valid = 8'h03;
        ev_kind  = '0;
      end else begin
        ev_valid = '0;
      end
      step();
    end
    ev_valid = '0;
    chk("kill_cycles", 32'(kill_hi), 32'd4);
    chk("kill_other", 32'(kill_bad), 32'd0);
    chk("kill_ready_low", 32'(ready_lo), 32'd6);
    chk("kill_enable", 32'(ch_enable), 32'hFF);
    rd_ch = 5'd0;
    #1 chk("kill_ch0_dropped", 32'(rd_pass), 32'd1);
    rd_ch = 5'd1;
    #1 chk("kill_ch1_counted", 32'(rd_pass), 32'd1);

    // Simultaneous fails ch5 and ch3, then a lone fail on ch6.
    event1(8'h28, 2'd1);
    chk("multi_fail", 32'({fail_act, fail_ch, fail_multi}), 32'({1'b1, 5'd3, 1'b1}));
    event1(8'h40, 2'd1);
    chk("single_fail", 32'({fail_act, fail_ch, fail_multi}), 32'({1'b1, 5'd6, 1'b0}));
    step();
    chk("fail_pulse_end", 32'(fail_act), 32'd0);
    event1(8'h01, 2'd3);
    chk("reserved_ignored", 32'({pass_act, fail_act}), 32'h0);

    // Saturation on ch4.
    rd_ch = 5'd4;
    for (int i = 0; i < 14; i++) event1(8'h10, 2'd0);
    chk("cnt_14", 32'(rd_pass), 32'd14);
    event1(8'h10, 2'd0);
    chk("cnt_15", 32'(rd_pass), 32'd15);
    for (int i = 0; i < 5; i++) event1(8'h10, 2'd0);
    chk("cnt_sat", 32'(rd_pass), 32'd15);

    // Reset in the middle of a KILL window acts immediately.
    send_cmd(4'd4, 8'hFF, 3'd7, 8'h02);
    wait_ready("off1");
    send_cmd(4'd5, 8'h01, 3'd1, 8'h00);
    step();
    step();
    chk("kill_active", 32'(ch_kill), 32'h29);
    #2 rst = 1'b1;
    #1;
    chk("async_kill_drop", 32'(ch_kill), 32'h0);
    chk("async_ready", 32'(cmd_ready), 32'd1);
    chk("async_enable", 32'(ch_enable), 32'hFF);
    chk("async_cnt", 32'(rd_pass), 32'd0);
    step();
    #2 rst = 1'b0;
    step();
    send_cmd(4'd4, 8'hFF, 3'd7, 8'h01);
    wait_ready("post_rst");
    chk("post_rst_cmd", 32'(ch_enable), 32'hFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
